// File: rtl/restoring_divider_pkg.sv
// ----------------------------------------------------------------------------
// restoring_divider_pkg
// Shared definitions for the restoring divider: FSM state encodings and the
// default operand width.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package restoring_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/restoring_divider_full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor slice (a - b - b_in); the borrow-propagating
// counterpart of the adder bit-slice.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module full_subtractor (
  output logic diff,
  output logic b_out,
  input  logic a,
  input  logic b,
  input  logic b_in
);

  assign diff  = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

`default_nettype wire

// File: rtl/restoring_divider.sv
// ----------------------------------------------------------------------------
// restoring_divider
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/done handshake. Trial subtraction uses a ripple chain of
// full_subtractor slices.
// Optional feature: RESTORING_DIVIDER_DIV_ZERO_EN -- when defined, a zero
// divisor finishes immediately with div_by_zero set; otherwise div_by_zero is
// tied low and a zero divisor runs the normal WIDTH-step algorithm.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int             CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;       // partial remainder R
  logic [WIDTH-1:0] quo_q, quo_d;       // working quotient / dividend shifter Q
  logic [WIDTH-1:0] dsr_q, dsr_d;       // latched divisor D
  logic [CW-1:0]    cnt_q, cnt_d;       // step counter
  logic [WIDTH-1:0] res_quo_q, res_quo_d;
  logic [WIDTH-1:0] res_rem_q, res_rem_d;

  // Shifted {R,Q} and the trial subtraction R - {0,D}
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] quo_shift;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] borrow_chain;
  logic             borrow;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

  // R never exceeds WIDTH bits between steps, so its top bit is never read.
  logic             unused_rem_msb;
  assign unused_rem_msb = rem_q[WIDTH];

  assign rem_shift       = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign quo_shift       = {quo_q[WIDTH-2:0], 1'b0};
  assign sub_b           = {1'b0, dsr_q};
  assign borrow_chain[0] = 1'b0;

  generate
    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
      full_subtractor u_fs (
        .diff  (trial[i]),
        .b_out (borrow_chain[i+1]),
        .a     (rem_shift[i]),
        .b     (sub_b[i]),
        .b_in  (borrow_chain[i])
      );
    end
  endgenerate

  assign borrow   = borrow_chain[WIDTH+1];
  assign step_rem = borrow ? rem_shift : trial;
  assign step_quo = {quo_shift[WIDTH-1:1], ~borrow};

`ifdef RESTORING_DIVIDER_DIV_ZERO_EN
  logic dbz_q, dbz_d;
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  // Next-state and datapath update; every target defaults to its current value
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    cnt_d     = cnt_q;
    res_quo_d = res_quo_q;
    res_rem_d = res_rem_q;
`ifdef RESTORING_DIVIDER_DIV_ZERO_EN
    dbz_d     = dbz_q;
`endif
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          rem_d   = '0;
          quo_d   = dividend;
          dsr_d   = divisor;
          cnt_d   = '0;
          state_d = DIV_RUN;
`ifdef RESTORING_DIVIDER_DIV_ZERO_EN
          dbz_d   = 1'b0;
          if (divisor == '0) begin
            state_d   = DIV_DONE;
            res_quo_d = '1;
            res_rem_d = dividend;
            dbz_d     = 1'b1;
          end
`endif
        end
      end
      DIV_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d   = DIV_DONE;
          res_quo_d = step_quo;
          res_rem_d = step_rem[WIDTH-1:0];
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= DIV_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      cnt_q     <= '0;
      res_quo_q <= '0;
      res_rem_q <= '0;
`ifdef RESTORING_DIVIDER_DIV_ZERO_EN
      dbz_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      cnt_q     <= cnt_d;
      res_quo_q <= res_quo_d;
      res_rem_q <= res_rem_d;
`ifdef RESTORING_DIVIDER_DIV_ZERO_EN
      dbz_q     <= dbz_d;
`endif
    end
  end

  assign busy      = (state_q == DIV_RUN);
  assign done      = (state_q == DIV_DONE);
  assign quotient  = res_quo_q;
  assign remainder = res_rem_q;

endmodule

`default_nettype wire

// File: tb/tb_restoring_divider.sv
// ----------------------------------------------------------------------------
// tb_restoring_divider
// Directed self-checking bench for restoring_divider (WIDTH = 8).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_restoring_divider;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [7:0] divisor  = 8'd0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] prev_q = 8'd0;
  logic [7:0] prev_r = 8'd0;

  restoring_divider #(.WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one division; lat is counted in edges after the accepting edge E0.
  task automatic run_div(input string tag, input logic [7:0] dvd, input logic [7:0] dvs,
                         input logic [7:0] eq, input logic [7:0] er, input int elat,
                         input int ebusy, input logic edbz, input bit inject);
    int lat;
    int bcnt;
    start = 1'b1; dividend = dvd; divisor = dvs;
    @(posedge clock); #1;
    start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    lat = 0;
    bcnt = 0;
    if (!done) begin
      check_eq({tag, "_hold_q"}, quotient, prev_q);
      check_eq({tag, "_hold_r"}, remainder, prev_r);
      check_eq({tag, "_dbz_clr"}, div_by_zero, 0);
    end
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (inject && lat == 2) begin
        start = 1'b1; dividend = 8'd9; divisor = 8'd9;
      end
      @(posedge clock); #1;
      start = 1'b0; dividend = 8'd0; divisor = 8'd0;
      lat++;
    end
    check_eq({tag, "_latency"}, lat, elat);
    check_eq({tag, "_busy_cycles"}, bcnt, ebusy);
    check_eq({tag, "_busy_in_done"}, busy, 0);
    check_eq({tag, "_quotient"}, quotient, eq);
    check_eq({tag, "_remainder"}, remainder, er);
    check_eq({tag, "_dbz"}, div_by_zero, edbz);
    @(posedge clock); #1;
    check_eq({tag, "_done_one_cycle"}, done, 0);
    check_eq({tag, "_q_held"}, quotient, eq);
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_q", quotient, 0);
    check_eq("rst_r", remainder, 0);
    check_eq("rst_dbz", div_by_zero, 0);

    run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 8, 8, 1'b0, 1'b0);
    run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 8, 8, 1'b0, 1'b0);
    run_div("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 8, 8, 1'b0, 1'b0);
`ifdef RESTORING_DIVIDER_DIV_ZERO_EN
    run_div("d42_0", 8'd42, 8'd0, 8'hFF, 8'd42, 0, 0, 1'b1, 1'b0);
`else
    run_div("d42_0", 8'd42, 8'd0, 8'hFF, 8'd42, 8, 8, 1'b0, 1'b0);
`endif
    run_div("d200_3_ign", 8'd200, 8'd3, 8'd66, 8'd2, 8, 8, 1'b0, 1'b1);
    run_div("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 8, 8, 1'b0, 1'b0);

    // Reset in the middle of a run
    start = 1'b1; dividend = 8'd77; divisor = 8'd5;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    check_eq("mid_busy_before_rst", busy, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_q", quotient, 0);
    check_eq("mid_rst_r", remainder, 0);
    check_eq("mid_rst_dbz", div_by_zero, 0);
    @(posedge clock); #1;
    check_eq("mid_rst_idle_busy", busy, 0);
    check_eq("mid_rst_idle_done", done, 0);
    prev_q = 8'd0;
    prev_r = 8'd0;
    run_div("d77_5", 8'd77, 8'd5, 8'd15, 8'd2, 8, 8, 1'b0, 1'b0);

    // Reset wins over a simultaneous start
    reset = 1'b1; start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clock); #1;
    reset = 1'b0; start = 1'b0;
    check_eq("rst_start_busy", busy, 0);
    check_eq("rst_start_q", quotient, 0);
    @(posedge clock); #1;
    check_eq("rst_start_busy2", busy, 0);
    check_eq("rst_start_done2", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
